// File: rtl/inst_decode.sv
// Instruction fetch/decode stage: fetches one word per decodePulse, decodes the
// RV32 fields and holds them on a valid/ready handshake toward dispatch.
module inst_decode #(
  parameter int         IMEM_LAT_MAX = 16,
  parameter logic [6:0] BNE_OP       = 7'b1100011
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [31:0] pc,
  input  logic        decodePulse,
  input  logic        pcChange,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  input  logic        imemReady,
  output logic [6:0]  operatorType,
  output logic [2:0]  operatorSubType,
  output logic        operatorFlag,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        issueValid,
  input  logic        issueReady,
  output logic        busy,
  output logic        illegalInst,
  output logic        fetchError
);

  localparam int CW = $clog2(IMEM_LAT_MAX + 1);
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          capture, illegal_nxt, ferr_nxt, legal;
  logic [6:0]    opcode;
  logic [31:0]   imm_dec;

  // Combinational decode of the word on the memory bus; only captured on imemReady.
  always_comb begin
    opcode  = imemData[6:0];
    legal   = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_L) ||
              (opcode == OP_S) || (opcode == BNE_OP);
    imm_dec = '0;
    if (opcode == OP_I || opcode == OP_L)
      imm_dec = {{20{imemData[31]}}, imemData[31:20]};
    else if (opcode == OP_S)
      imm_dec = {{20{imemData[31]}}, imemData[31:25], imemData[11:7]};
    else if (opcode == BNE_OP)
      imm_dec = {{19{imemData[31]}}, imemData[31], imemData[7], imemData[30:25],
                 imemData[11:8], 1'b0};
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    capture      = 1'b0;
    illegal_nxt  = 1'b0;
    ferr_nxt     = 1'b0;
    if (pcChange) begin
      state_nxt    = IDLE;
      wait_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt_nxt = '0;
          if (decodePulse) state_nxt = FETCH;
        end
        FETCH: begin
          if (imemReady) begin
            capture      = 1'b1;
            wait_cnt_nxt = '0;
            state_nxt    = legal ? ISSUE : IDLE;
            illegal_nxt  = !legal;
          end else if (wait_cnt == CW'(IMEM_LAT_MAX - 1)) begin
            ferr_nxt     = 1'b1;
            wait_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
        ISSUE: if (issueReady) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      illegalInst <= 1'b0;
      fetchError  <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      illegalInst <= illegal_nxt;
      fetchError  <= ferr_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      imemAddr        <= '0;
      operatorType    <= '0;
      operatorSubType <= '0;
      operatorFlag    <= 1'b0;
      rd              <= '0;
      rs1             <= '0;
      rs2             <= '0;
      imm             <= '0;
    end else begin
      if (state == IDLE && decodePulse && !pcChange) imemAddr <= pc;
      if (capture) begin
        operatorType    <= legal ? opcode : 7'd0;
        operatorSubType <= imemData[14:12];
        operatorFlag    <= imemData[30];
        rd              <= imemData[11:7];
        rs1             <= imemData[19:15];
        rs2             <= imemData[24:20];
        imm             <= imm_dec;
      end
    end
  end

  assign imemReq    = (state == FETCH);
  assign issueValid = (state == ISSUE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_inst_decode.sv
// Directed bench for inst_decode: fetch/decode, handshake stall, illegal,
// fetch timeout, flush and reset corner cases.
module tb_inst_decode;
  logic        clock = 1'b0;
  logic        resetN;
  logic [31:0] pc;
  logic        decodePulse, pcChange;
  logic        imemReq;
  logic [31:0] imemAddr, imemData;
  logic        imemReady;
  logic [6:0]  operatorType;
  logic [2:0]  operatorSubType;
  logic        operatorFlag;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        issueValid, issueReady, busy, illegalInst, fetchError;

  int passed = 0;
  int total  = 0;
  int xfers  = 0;
  int xfers0;
  logic [31:0] inst;

  inst_decode dut (
    .clock(clock), .resetN(resetN), .pc(pc), .decodePulse(decodePulse),
    .pcChange(pcChange), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemData(imemData), .imemReady(imemReady), .operatorType(operatorType),
    .operatorSubType(operatorSubType), .operatorFlag(operatorFlag),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .issueValid(issueValid),
    .issueReady(issueReady), .busy(busy), .illegalInst(illegalInst),
    .fetchError(fetchError)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (resetN && issueValid && issueReady && !pcChange) xfers <= xfers + 1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
    pc = addr; decodePulse = 1'b1;
    step();
    decodePulse = 1'b0; imemReady = 1'b1; imemData = word;
    step();
    imemReady = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; pc = '0; decodePulse = 1'b0; pcChange = 1'b0;
    imemData = '0; imemReady = 1'b0; issueReady = 1'b0;
    step(); step();
    chk("rst_req", imemReq, 0);
    chk("rst_addr", imemAddr, 0);
    chk("rst_valid", issueValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_optype", operatorType, 0);
    chk("rst_imm", imm, 0);
    chk("rst_pulses", {illegalInst, fetchError}, 0);
    resetN = 1'b1;
    step();

    // bne x1,x2,+8 at pc 5, minimum latency
    pc = 32'd5; decodePulse = 1'b1;
    step();
    decodePulse = 1'b0;
    chk("bne_req", imemReq, 1);
    chk("bne_addr", imemAddr, 5);
    chk("bne_busy", busy, 1);
    chk("bne_valid_early", issueValid, 0);
    imemReady = 1'b1; imemData = 32'h0020_9463;
    step();
    imemReady = 1'b0;
    chk("bne_valid", issueValid, 1);
    chk("bne_req_low", imemReq, 0);
    chk("bne_optype", operatorType, 7'b1100011);
    chk("bne_sub", operatorSubType, 3'b001);
    chk("bne_flag", operatorFlag, 0);
    chk("bne_rs1", rs1, 1);
    chk("bne_rs2", rs2, 2);
    chk("bne_rd", rd, 8);
    chk("bne_imm", imm, 8);
    issueReady = 1'b1;
    step();
    issueReady = 1'b0;
    chk("bne_done_valid", issueValid, 0);
    chk("bne_done_busy", busy, 0);
    chk("bne_xfer", xfers, 1);

    // addi x3,x0,-1 with three stalled cycles
    xfers0 = xfers;
    fetch(32'd9, 32'hFFF0_0193);
    for (int i = 0; i < 3; i++) begin
      chk("addi_hold_valid", issueValid, 1);
      chk("addi_hold_imm", imm, 32'hFFFF_FFFF);
      chk("addi_hold_rd", rd, 3);
      chk("addi_hold_optype", operatorType, 7'b0010011);
      if (i < 2) step();
    end
    chk("addi_addr", imemAddr, 9);
    issueReady = 1'b1;
    step();
    issueReady = 1'b0;
    chk("addi_done_valid", issueValid, 0);
    chk("addi_single_xfer", xfers, xfers0 + 1);

    // illegal opcode
    fetch(32'd12, 32'h0000_007F);
    chk("ill_pulse", illegalInst, 1);
    chk("ill_optype", operatorType, 0);
    chk("ill_valid", issueValid, 0);
    chk("ill_busy", busy, 0);
    step();
    chk("ill_pulse_end", illegalInst, 0);
    chk("ill_valid_after", issueValid, 0);

    // memory never answers: error after 16 FETCH cycles
    pc = 32'd20; decodePulse = 1'b1;
    step();
    decodePulse = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_wait_req", imemReq, 1);
      chk("to_wait_err", fetchError, 0);
    end
    step();
    chk("to_err", fetchError, 1);
    chk("to_req_low", imemReq, 0);
    chk("to_busy_low", busy, 0);
    imemReady = 1'b1; imemData = 32'hFFF0_0193;
    step();
    imemReady = 1'b0;
    chk("to_err_end", fetchError, 0);
    chk("idle_ready_ignored", issueValid, 0);

    // flush wins over transfer in ISSUE; R-type imm is zero
    xfers0 = xfers;
    fetch(32'd30, 32'h0020_81B3);
    chk("add_imm", imm, 0);
    chk("add_valid", issueValid, 1);
    issueReady = 1'b1; pcChange = 1'b1;
    step();
    issueReady = 1'b0; pcChange = 1'b0;
    chk("flush_valid", issueValid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_no_xfer", xfers, xfers0);
    chk("flush_no_pulse", {illegalInst, fetchError}, 0);

    // flush wins over decodePulse in IDLE
    pc = 32'd40; decodePulse = 1'b1; pcChange = 1'b1;
    step();
    decodePulse = 1'b0; pcChange = 1'b0;
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_req", imemReq, 0);

    // sw x2,-4(x1): split store immediate
    inst = {7'h7F, 5'd2, 5'd1, 3'b010, 5'b11100, 7'b0100011};
    fetch(32'd44, inst);
    chk("sw_imm", imm, 32'hFFFF_FFFC);
    chk("sw_sub", operatorSubType, 3'b010);
    issueReady = 1'b1;
    step();
    issueReady = 1'b0;

    // reset while fetching, late imemReady ignored
    pc = 32'd50; decodePulse = 1'b1;
    step();
    decodePulse = 1'b0;
    chk("rf_req", imemReq, 1);
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    chk("rf_req_low", imemReq, 0);
    chk("rf_addr", imemAddr, 0);
    chk("rf_busy", busy, 0);
    chk("rf_imm", imm, 0);
    chk("rf_optype", operatorType, 0);
    imemReady = 1'b1; imemData = 32'h0020_9463;
    step();
    imemReady = 1'b0;
    chk("rf_late_valid", issueValid, 0);
    chk("rf_late_busy", busy, 0);
    chk("rf_late_pulses", {illegalInst, fetchError}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
